// File: rtl/hdmi_scan_sequencer_if.sv
// Raster/handshake bundle between the HDMI scan sequencer and its consumers
// (TMDS encoder, playback scanline buffer) plus the start pulse from the PPU side.
interface hdmi_scan_sequencer_if;
    logic       start_sync;
    logic [9:0] hx;
    logic [9:0] hy;
    logic       hsync;
    logic       vsync;
    logic       de;
    logic       draw;
    logic [7:0] rd_idx;
    logic [7:0] rd_line;
    logic       load_line;
    logic       frame_start;
    logic       locked;
    logic       sync_err;

    modport master (
        input  start_sync,
        output hx, hy, hsync, vsync, de, draw, rd_idx, rd_line,
        output load_line, frame_start, locked, sync_err
    );

    modport slave (
        output start_sync,
        input  hx, hy, hsync, vsync, de, draw, rd_idx, rd_line,
        input  load_line, frame_start, locked, sync_err
    );
endinterface

// File: rtl/hdmi_scan_sequencer.sv
// HDMI raster sequencer for the upscaled NES picture: counters, syncs, upscale window and
// playback-buffer strobes. Define HDMI_SEQ_RESYNC_EN to restart the raster on a misaligned start_sync.
module hdmi_scan_sequencer #(
    parameter int unsigned ISCREEN_WIDTH  = 256,
    parameter int unsigned ISCREEN_HEIGHT = 240,
    parameter int unsigned OFRAME_WIDTH   = 858,
    parameter int unsigned OFRAME_HEIGHT  = 525,
    parameter int unsigned OSCREEN_WIDTH  = 720,
    parameter int unsigned OSCREEN_HEIGHT = 480,
    parameter int unsigned SUB_X          = 2,
    parameter int unsigned SUB_Y          = 2,
    parameter int unsigned HSYNC_START    = 736,
    parameter int unsigned HSYNC_END      = 798,
    parameter int unsigned VSYNC_START    = 489,
    parameter int unsigned VSYNC_END      = 495,
    parameter bit          SYNC_ACTIVE    = 1'b0,
    parameter int unsigned OSCREEN_SHIFT  = (OSCREEN_WIDTH - ISCREEN_WIDTH * SUB_X) >> 1
) (
    input logic                   clk_h,
    input logic                   rst_h,
    hdmi_scan_sequencer_if.master bus
);

    localparam int unsigned SxW = (SUB_X > 1) ? $clog2(SUB_X) : 1;
    localparam int unsigned SyW = (SUB_Y > 1) ? $clog2(SUB_Y) : 1;

    localparam logic [9:0]     HxLast    = 10'(OFRAME_WIDTH - 1);
    localparam logic [9:0]     HyLast    = 10'(OFRAME_HEIGHT - 1);
    localparam logic [9:0]     OscW      = 10'(OSCREEN_WIDTH);
    localparam logic [9:0]     OscH      = 10'(OSCREEN_HEIGHT);
    localparam logic [9:0]     WinX0     = 10'(OSCREEN_SHIFT);
    localparam logic [9:0]     WinX1     = 10'(OSCREEN_SHIFT + ISCREEN_WIDTH * SUB_X);
    localparam logic [9:0]     WinH      = 10'(ISCREEN_HEIGHT * SUB_Y);
    localparam logic [9:0]     HsStart   = 10'(HSYNC_START);
    localparam logic [9:0]     HsEnd     = 10'(HSYNC_END);
    localparam logic [9:0]     VsStart   = 10'(VSYNC_START);
    localparam logic [9:0]     VsEnd     = 10'(VSYNC_END);
    localparam logic [7:0]     RdLineMax = 8'(ISCREEN_HEIGHT - 1);
    localparam logic [SxW-1:0] SubXLast  = SxW'(SUB_X - 1);
    localparam logic [SyW-1:0] SubYLast  = SyW'(SUB_Y - 1);

    typedef enum logic {StWait, StRun} state_e;

    state_e         state_q, state_d;
    logic [9:0]     hx_q, hx_d, hy_q, hy_d;
    logic [SxW-1:0] sub_x_q, sub_x_d;
    logic [SyW-1:0] sub_y_q, sub_y_d;
    logic [7:0]     rd_idx_q, rd_idx_d, rd_line_q, rd_line_d;
    logic           hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d, draw_q, draw_d;
    logic           load_q, load_d, frame_q, frame_d, locked_q, locked_d, err_q, err_d;
    logic           restart, new_line, aligned, run_d;

    always_comb begin
        state_d  = state_q;
        hx_d     = hx_q;
        hy_d     = hy_q;
        err_d    = err_q;
        restart  = 1'b0;
        new_line = 1'b0;
        aligned  = ((hx_q == HxLast) && (hy_q == HyLast)) || ((hx_q == '0) && (hy_q == '0));

        unique case (state_q)
            StWait: begin
                hx_d = '0;
                hy_d = '0;
                if (bus.start_sync) begin
                    state_d = StRun;
                    restart = 1'b1;
                end
            end
            StRun: begin
                if (bus.start_sync && !aligned) begin
                    err_d = 1'b1;
`ifdef HDMI_SEQ_RESYNC_EN
                    restart = 1'b1;
`endif
                end
                if (restart) begin
                    hx_d = '0;
                    hy_d = '0;
                end else if (hx_q == HxLast) begin
                    hx_d     = '0;
                    new_line = 1'b1;
                    hy_d     = (hy_q == HyLast) ? '0 : hy_q + 10'd1;
                end else begin
                    hx_d = hx_q + 10'd1;
                end
            end
        endcase

        run_d    = (state_d == StRun);
        locked_d = run_d;
        frame_d  = restart || (new_line && (hy_q == HyLast));

        // Sub-line phase picks which replicated output line triggers the next buffer load.
        if (frame_d)       sub_y_d = '0;
        else if (new_line) sub_y_d = (sub_y_q == SubYLast) ? '0 : sub_y_q + SyW'(1);
        else               sub_y_d = sub_y_q;

        load_d = frame_d || (new_line && (sub_y_d == '0) && (hy_d < WinH));

        if (frame_d)                             rd_line_d = '0;
        else if (load_d && rd_line_q != RdLineMax) rd_line_d = rd_line_q + 8'd1;
        else                                     rd_line_d = rd_line_q;

        de_d   = run_d && (hx_d < OscW) && (hy_d < OscH);
        draw_d = run_d && (hx_d >= WinX0) && (hx_d < WinX1) && (hy_d < WinH);

        // Source index advances once every SUB_X output pixels, restarting at the window edge.
        if (!draw_d || (hx_d == WinX0)) begin
            sub_x_d  = '0;
            rd_idx_d = '0;
        end else if (sub_x_q == SubXLast) begin
            sub_x_d  = '0;
            rd_idx_d = rd_idx_q + 8'd1;
        end else begin
            sub_x_d  = sub_x_q + SxW'(1);
            rd_idx_d = rd_idx_q;
        end

        hsync_d = (run_d && (hx_d >= HsStart) && (hx_d < HsEnd)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_d = (run_d && (hy_d >= VsStart) && (hy_d < VsEnd)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    end

    always_ff @(posedge clk_h or posedge rst_h) begin
        if (rst_h) begin
            state_q   <= StWait;
            hx_q      <= '0;
            hy_q      <= '0;
            sub_x_q   <= '0;
            sub_y_q   <= '0;
            rd_idx_q  <= '0;
            rd_line_q <= '0;
            hsync_q   <= ~SYNC_ACTIVE;
            vsync_q   <= ~SYNC_ACTIVE;
            de_q      <= 1'b0;
            draw_q    <= 1'b0;
            load_q    <= 1'b0;
            frame_q   <= 1'b0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            hx_q      <= hx_d;
            hy_q      <= hy_d;
            sub_x_q   <= sub_x_d;
            sub_y_q   <= sub_y_d;
            rd_idx_q  <= rd_idx_d;
            rd_line_q <= rd_line_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            de_q      <= de_d;
            draw_q    <= draw_d;
            load_q    <= load_d;
            frame_q   <= frame_d;
            locked_q  <= locked_d;
            err_q     <= err_d;
        end
    end

    assign bus.hx          = hx_q;
    assign bus.hy          = hy_q;
    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.de          = de_q;
    assign bus.draw        = draw_q;
    assign bus.rd_idx      = rd_idx_q;
    assign bus.rd_line     = rd_line_q;
    assign bus.load_line   = load_q;
    assign bus.frame_start = frame_q;
    assign bus.locked      = locked_q;
    assign bus.sync_err    = err_q;

endmodule

// File: tb/tb_hdmi_scan_sequencer.sv
// Scoreboard bench for hdmi_scan_sequencer on a scaled-down raster (64x16 frame, 16x6 source)
// so whole frames fit in a short run; a reference raster model feeds the expected queue.
module tb_hdmi_scan_sequencer;

    localparam int IW = 16, IH = 6, FW = 64, FH = 16, OSW = 48, OSH = 14;
    localparam int SUBX = 2, SUBY = 2, HSS = 52, HSE = 58, VSS = 13, VSE = 15;
    localparam int SHIFT = (OSW - IW * SUBX) >> 1;  // 8

    logic clk_h = 1'b0;
    logic rst_h = 1'b1;
    always #5 clk_h = ~clk_h;

    hdmi_scan_sequencer_if bus ();

    hdmi_scan_sequencer #(
        .ISCREEN_WIDTH (IW),  .ISCREEN_HEIGHT(IH),  .OFRAME_WIDTH  (FW), .OFRAME_HEIGHT(FH),
        .OSCREEN_WIDTH (OSW), .OSCREEN_HEIGHT(OSH), .SUB_X         (SUBX), .SUB_Y      (SUBY),
        .HSYNC_START   (HSS), .HSYNC_END     (HSE), .VSYNC_START   (VSS), .VSYNC_END    (VSE),
        .SYNC_ACTIVE   (1'b0)
    ) dut (
        .clk_h (clk_h),
        .rst_h (rst_h),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference raster state, advanced once per clock.
    bit m_run = 0, m_err = 0;
    int m_hx = 0, m_hy = 0;
    logic [43:0] exp_q[$];

    task automatic check(input string name, input logic [43:0] act, input logic [43:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %h want %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [43:0] dut_out();
        return {bus.hx, bus.hy, bus.hsync, bus.vsync, bus.de, bus.draw, bus.rd_idx, bus.rd_line,
                bus.load_line, bus.frame_start, bus.locked, bus.sync_err};
    endfunction

    function automatic logic [43:0] model_out();
        logic       dr, de, hs, vs, ld, fs;
        logic [7:0] idx, line;
        int         ln;
        dr   = m_run && m_hx >= SHIFT && m_hx < SHIFT + IW * SUBX && m_hy < IH * SUBY;
        de   = m_run && m_hx < OSW && m_hy < OSH;
        idx  = dr ? 8'((m_hx - SHIFT) / SUBX) : 8'd0;
        ln   = (m_hy / SUBY > IH - 1) ? IH - 1 : m_hy / SUBY;
        line = m_run ? 8'(ln) : 8'd0;
        hs   = (m_run && m_hx >= HSS && m_hx < HSE) ? 1'b0 : 1'b1;
        vs   = (m_run && m_hy >= VSS && m_hy < VSE) ? 1'b0 : 1'b1;
        ld   = m_run && m_hx == 0 && (m_hy % SUBY) == 0 && m_hy < IH * SUBY;
        fs   = m_run && m_hx == 0 && m_hy == 0;
        return {10'(m_hx), 10'(m_hy), hs, vs, de, dr, idx, line, ld, fs, m_run, m_err};
    endfunction

    always @(posedge clk_h) begin
        if (rst_h) begin
            m_run = 0; m_err = 0; m_hx = 0; m_hy = 0;
        end else if (!m_run) begin
            if (bus.start_sync) begin
                m_run = 1; m_hx = 0; m_hy = 0;
            end
        end else begin
            bit aligned, resync;
            aligned = (m_hx == FW - 1 && m_hy == FH - 1) || (m_hx == 0 && m_hy == 0);
            resync  = 0;
            if (bus.start_sync && !aligned) begin
                m_err = 1;
`ifdef HDMI_SEQ_RESYNC_EN
                resync = 1;
`endif
            end
            if (resync) begin
                m_hx = 0; m_hy = 0;
            end else if (m_hx == FW - 1) begin
                m_hx = 0;
                m_hy = (m_hy == FH - 1) ? 0 : m_hy + 1;
            end else begin
                m_hx++;
            end
        end
        exp_q.push_back(model_out());
    end

    // Monitor: one registered output word per clock; also gathers frame statistics.
    int cyc = 0, last_fs = 0, first_period = -1, first_loads = -1, loads_acc = 0;
    int max_rd_line = 0, max_rd_idx = 0;
    bit have_fs = 0;

    initial begin
        logic [43:0] e;
        forever begin
            @(posedge clk_h);
            #1;
            cyc++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL queue t=%0t got empty want entry", $time);
            end else begin
                e = exp_q.pop_front();
                check("raster", dut_out(), e);
            end
            if (bus.frame_start === 1'b1) begin
                if (have_fs && first_period < 0) begin
                    first_period = cyc - last_fs;
                    first_loads  = loads_acc;
                end
                have_fs   = 1;
                last_fs   = cyc;
                loads_acc = (bus.load_line === 1'b1) ? 1 : 0;
            end else if (bus.load_line === 1'b1) begin
                loads_acc++;
            end
            if (int'(bus.rd_line) > max_rd_line) max_rd_line = int'(bus.rd_line);
            if (int'(bus.rd_idx) > max_rd_idx) max_rd_idx = int'(bus.rd_idx);
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_h);
            #1;
        end
    endtask

    task automatic pulse_sync();
        bus.start_sync = 1'b1;
        step(1);
        bus.start_sync = 1'b0;
    endtask

    task automatic wait_model(input int x, input int y);
        int n = 0;
        while (!(m_run && m_hx == x && m_hy == y) && n < 3000) begin
            step(1);
            n++;
        end
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL wait_model t=%0t got timeout want hx=%0d hy=%0d", $time, x, y);
        end
    endtask

    initial begin
        bus.start_sync = 1'b0;
        step(3);
        rst_h = 1'b0;
        step(6);
        check("idle_sync_de", 44'({bus.hsync, bus.vsync, bus.de, bus.draw, bus.locked}),
              44'(5'b11000));
        pulse_sync();
        check("start_pulse", 44'({bus.hx, bus.hy, bus.frame_start, bus.load_line, bus.locked}),
              44'({10'd0, 10'd0, 3'b111}));
        step(10);
        check("rd_idx_hx10", 44'({bus.hx, bus.draw, bus.rd_idx}), 44'({10'd10, 1'b1, 8'd1}));

        // Aligned pulse at the natural wrap, then again at (0,0).
        wait_model(FW - 1, FH - 1);
        pulse_sync();
        pulse_sync();
        step(3);
        check("aligned_err", 44'(bus.sync_err), 44'd0);
        check("aligned_hx", 44'({bus.hx, bus.hy}), 44'({10'd4, 10'd0}));
        check("frame_period", 44'(first_period), 44'd1024);
        check("loads_per_frame", 44'(first_loads), 44'd6);
        check("max_rd_line", 44'(max_rd_line), 44'd5);
        check("max_rd_idx", 44'(max_rd_idx), 44'd15);

        // Misaligned pulse at (20,3).
        wait_model(20, 3);
        pulse_sync();
        check("misalign_err", 44'({bus.sync_err, bus.locked}), 44'(2'b11));
`ifdef HDMI_SEQ_RESYNC_EN
        check("misalign_pos", 44'({bus.hx, bus.hy, bus.frame_start}), 44'({10'd0, 10'd0, 1'b1}));
`else
        check("misalign_pos", 44'({bus.hx, bus.hy, bus.frame_start}), 44'({10'd21, 10'd3, 1'b0}));
`endif
        wait_model(FW - 1, FH - 1);
        step(200);

        // Asynchronous reset mid-frame.
        wait_model(40, 8);
        #1 rst_h = 1'b1;
        #1 check("async_reset", dut_out(),
                 {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 4'b0000});
        step(2);
        rst_h = 1'b0;
        step(5);
        check("post_reset_idle", 44'({bus.hx, bus.hy, bus.locked}), 44'd0);
        pulse_sync();
        step(150);
        check("restart_err_clear", 44'({bus.sync_err, bus.locked}), 44'(2'b01));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
